// File: rtl/clap_pattern_decoder.sv
// Clap/pulse-pattern detector: synchronises a sensor pulse, counts claps inside a
// timed window with post-clap blanking, then reports the count and toggles one load bit.
module clap_pattern_decoder #(
  parameter int BLANK_CYC  = 5_000_000,
  parameter int WINDOW_CYC = 100_000_000,
  parameter int MAX_CLAPS  = 4,
  localparam int CW        = $clog2(MAX_CLAPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 aplauso,
  output logic [CW-1:0]        clap_count,
  output logic                 count_valid,
  output logic                 busy,
  output logic                 overflow,
  output logic [MAX_CLAPS-1:0] out_state
);

  localparam int WW = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW_CYC - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] MAX_COUNT  = CW'(MAX_CLAPS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    LISTEN = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t        state_r, next_s;
  logic          s1_r, s2_r, s3_r, edge_r;
  logic [CW-1:0] count_r, count_s;
  logic          ovf_r, ovf_s;
  logic [WW-1:0] win_cnt_r, win_cnt_s;
  logic [BW-1:0] blank_cnt_r, blank_cnt_s;
  logic          report_s;

  // One-hot toggle mask for a window that closed with count n (n >= 1)
  function automatic logic [MAX_CLAPS-1:0] toggle_mask(input logic [CW-1:0] n);
    toggle_mask = MAX_CLAPS'(1) << (n - CW'(1));
  endfunction

  // Synchroniser, rise detector and all FSM/output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_r        <= 1'b0;
      s2_r        <= 1'b0;
      s3_r        <= 1'b0;
      edge_r      <= 1'b0;
      state_r     <= IDLE;
      count_r     <= '0;
      ovf_r       <= 1'b0;
      win_cnt_r   <= '0;
      blank_cnt_r <= '0;
      clap_count  <= '0;
      count_valid <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      out_state   <= '0;
    end else begin
      s1_r        <= aplauso;
      s2_r        <= s1_r;
      s3_r        <= s2_r;
      edge_r      <= s2_r & ~s3_r;
      state_r     <= next_s;
      count_r     <= count_s;
      ovf_r       <= ovf_s;
      win_cnt_r   <= win_cnt_s;
      blank_cnt_r <= blank_cnt_s;
      count_valid <= report_s;
      busy        <= (next_s == BLANK) || (next_s == LISTEN);
      if (report_s) begin
        clap_count <= count_r;
        overflow   <= ovf_r;
        out_state  <= out_state ^ toggle_mask(count_r);
      end else begin
        clap_count <= clap_count;
        overflow   <= overflow;
        out_state  <= out_state;
      end
    end
  end

  // Next-state logic; window expiry outranks blank expiry and any same-cycle clap
  always_comb begin
    next_s      = state_r;
    count_s     = count_r;
    ovf_s       = ovf_r;
    win_cnt_s   = win_cnt_r;
    blank_cnt_s = blank_cnt_r;
    report_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (edge_r) begin
          next_s      = BLANK;
          count_s     = CW'(1);
          win_cnt_s   = '0;
          blank_cnt_s = '0;
        end else begin
          next_s = IDLE;
        end
      end
      BLANK: begin
        win_cnt_s = win_cnt_r + WW'(1);
        if (win_cnt_r == WIN_LAST) begin
          next_s    = REPORT;
          report_s  = 1'b1;
          win_cnt_s = '0;
        end else if (blank_cnt_r == BLANK_LAST) begin
          next_s = LISTEN;
        end else begin
          blank_cnt_s = blank_cnt_r + BW'(1);
        end
      end
      LISTEN: begin
        win_cnt_s = win_cnt_r + WW'(1);
        if (win_cnt_r == WIN_LAST) begin
          next_s    = REPORT;
          report_s  = 1'b1;
          win_cnt_s = '0;
        end else if (edge_r) begin
          if (count_r < MAX_COUNT) begin
            count_s = count_r + CW'(1);
          end else begin
            ovf_s = 1'b1;
          end
          blank_cnt_s = '0;
          next_s      = BLANK;
        end else begin
          next_s = LISTEN;
        end
      end
      REPORT: begin
        ovf_s  = 1'b0;
        next_s = IDLE;
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_clap_pattern_decoder.sv
// Randomised and directed bench for clap_pattern_decoder, checked every cycle against
// a window/time-arithmetic reference model.
module tb_clap_pattern_decoder;
  localparam int BLANK  = 4;
  localparam int WINDOW = 40;
  localparam int MAXC   = 3;
  localparam int CW     = $clog2(MAXC + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            aplauso = 1'b0;
  logic [CW-1:0]   clap_count;
  logic            count_valid;
  logic            busy;
  logic            overflow;
  logic [MAXC-1:0] out_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  clap_pattern_decoder #(.BLANK_CYC(BLANK), .WINDOW_CYC(WINDOW), .MAX_CLAPS(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .aplauso(aplauso), .clap_count(clap_count),
    .count_valid(count_valid), .busy(busy), .overflow(overflow), .out_state(out_state)
  );

  always #5 clk = ~clk;

  // Reference model: a window is a time span from the opening clap, claps are
  // accepted when far enough from the previous accepted one
  int         cyc = 0;
  logic [3:0] hist = 4'b0;
  bit         open = 1'b0;
  int         p0, last, cnt;
  int         rep_at = -100;
  int         e_cc = 0, e_out = 0;
  bit         e_valid = 1'b0, e_busy = 1'b0, e_ovf = 1'b0;
  bit         ev;

  always @(posedge clk) begin
    if (!rst_n) begin
      hist = 4'b0; open = 1'b0; cnt = 0; rep_at = -100;
      e_cc = 0; e_out = 0; e_valid = 1'b0; e_busy = 1'b0; e_ovf = 1'b0;
    end else begin
      ev = hist[2] & ~hist[3];
      e_valid = 1'b0;
      if (open) begin
        if (cyc - p0 == WINDOW) begin
          e_cc    = (cnt > MAXC) ? MAXC : cnt;
          e_ovf   = (cnt > MAXC);
          e_out   = e_out ^ (1 << (e_cc - 1));
          e_valid = 1'b1;
          open    = 1'b0;
          rep_at  = cyc;
        end else if (ev && (cyc - last > BLANK)) begin
          cnt++;
          last = cyc;
        end
      end else if (ev && (cyc != rep_at + 1)) begin
        open = 1'b1; p0 = cyc; last = cyc; cnt = 1;
      end
      e_busy = open;
      hist = {hist[2:0], aplauso};
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Compare all outputs away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      check("clap_count", 32'(clap_count), 32'(e_cc));
      check("count_valid", 32'(count_valid), 32'(e_valid));
      check("busy", 32'(busy), 32'(e_busy));
      check("overflow", 32'(overflow), 32'(e_ovf));
      check("out_state", 32'(out_state), 32'(e_out));
    end
  end

  task automatic pulse(input int w);
    aplauso = 1'b1;
    repeat (w) @(negedge clk);
    aplauso = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  initial begin
    @(posedge clk);
    check_en = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    // single clap
    pulse(2); idle(60);
    // two claps 10 apart, twice
    repeat (2) begin pulse(2); idle(8); pulse(2); idle(60); end
    // second clap inside blanking, then just after it
    pulse(1); idle(1); pulse(1); idle(60);
    pulse(1); idle(4); pulse(1); idle(60);
    // five claps 6 apart, then a single
    repeat (5) begin pulse(1); idle(5); end
    idle(40);
    pulse(1); idle(60);
    // clap on the last window cycle, then right after the report
    pulse(1); idle(39); pulse(1); idle(1); pulse(1); idle(60);
    // reset mid-window, then a normal window
    pulse(2); idle(18);
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    idle(10); pulse(2); idle(60);
    // held-high input
    pulse(25); idle(60);
    // random traffic
    for (int i = 0; i < 80; i++) begin
      pulse($urandom_range(1, 4));
      idle($urandom_range(1, 30));
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0; idle(1); rst_n = 1'b1;
      end
    end
    idle(60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/clap_pattern_decoder.md
Name: clap_pattern_decoder

Overview:
Generalised clap/pulse-pattern detector for the lamp/laser control path. It synchronises an asynchronous clap pulse and opens a timed listening window on the first clap. It counts claps, with a blanking period after each one, up to a parametrised maximum. At window close it reports the count and toggles a per-pattern output bit, so one block drives up to MAX_CLAPS independent loads instead of one fixed on/off output.

Parameters:
BLANK_CYC, 5_000_000, clocks ignored after each accepted clap (100 ms at 50 MHz); must be >= 1
WINDOW_CYC, 100_000_000, clocks from first accepted clap to report (2 s at 50 MHz); must be > BLANK_CYC
MAX_CLAPS, 4, highest distinct count; also the number of toggle outputs; >= 1
CW, $clog2(MAX_CLAPS+1), localparam, width of the count

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk
aplauso  in  1  asynchronous clap pulse from sensor, active high, any width >= 1 clk
clap_count  out  CW  count of last completed window, saturated at MAX_CLAPS; held until next report
count_valid  out  1  one-cycle pulse when clap_count updates
busy  out  1  high while a window is open (BLANK or LISTEN)
overflow  out  1  high with count_valid if more than MAX_CLAPS claps were seen in that window; held with clap_count
out_state  out  MAX_CLAPS  toggle bits; bit k flips when a window closes with count k+1

Behaviour:
- Reset (rst_n=0 at rising clk): state=IDLE; sync flops, count, timers = 0; clap_count=0, count_valid=0, busy=0, overflow=0, out_state=0. Reset mid-window aborts it with no report and no toggle.
- Input: 2-flop synchroniser (s1, s2) plus a previous-value flop s3. edge = s2 & ~s3, registered logic. A clean rise on aplauso produces edge in the 3rd clk after the first high sample. A held-high input produces exactly one edge.
- State machine: IDLE, BLANK, LISTEN, REPORT.
- IDLE: on edge, count<=1, win_cnt<=0, blank_cnt<=0, go to BLANK. Otherwise stay.
- BLANK: edges are ignored. blank_cnt increments. When blank_cnt==BLANK_CYC-1, go to LISTEN.
- LISTEN: on edge, if count<MAX_CLAPS then count<=count+1, else ovf_r<=1. In both cases blank_cnt<=0 and go to BLANK.
- Window timer: win_cnt increments every cycle in BLANK and LISTEN. When win_cnt==WINDOW_CYC-1, go to REPORT next cycle. This takes priority over the blank-expiry transition and over any same-cycle edge; that edge is dropped and does not count.
- REPORT (exactly 1 cycle): count_valid=1, clap_count<=count, overflow<=ovf_r, out_state[count-1] toggles; then ovf_r<=0 and go to IDLE. Edges during REPORT are ignored. An edge in the first IDLE cycle after REPORT is accepted.
- Latency: count_valid asserts WINDOW_CYC+1 cycles after the first-clap edge cycle.
- busy = 1 in BLANK and LISTEN, 0 in IDLE and REPORT.
- Counters: win_cnt and blank_cnt are sized by $clog2 of their limits. They never wrap within a window.
- count is never 0 in REPORT, so there is no out-of-range toggle index.

Test Plan:
(Bench params: BLANK_CYC=4, WINDOW_CYC=40, MAX_CLAPS=3. E = first-clap edge cycle.)
1. Single clap: aplauso high 2 clk -> count_valid pulse at E+41, clap_count=1, overflow=0, out_state=3'b001, busy high from E+1 to E+40.
2. Two claps, second pulse giving edge at E+10 -> clap_count=2, out_state bit1 toggles. Repeat the pattern -> bit1 returns to 0.
3. Second pulse with edge at E+2 (inside blanking) -> ignored, clap_count=1. Same pulse with edge at E+5 -> clap_count=2.
4. Five claps spaced 6 clk apart -> clap_count=3, overflow=1 for that window. Next single-clap window -> overflow=0.
5. Edge coinciding with win_cnt==39 -> not counted, REPORT next cycle. Clap in the cycle after count_valid -> new window opens and reports 41 cycles later.
6. rst_n low for 1 clk at E+20 -> no count_valid, all outputs 0, busy=0. Following clap behaves as in scenario 1.
